// File: rtl/scan_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : scan_seq_pkg
//  Description : Shared states and constants for the on-chip scan sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
package scan_seq_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SHIFT   = 3'd1,
        SE_FALL = 3'd2,
        CAPTURE = 3'd3,
        SE_RISE = 3'd4,
        DONE    = 3'd5
    } state_t;

    // Tap mask for x^16+x^14+x^13+x^11+1 (bits 15, 13, 12, 10 feed bit 0)
    localparam logic [15:0] LFSR_TAPS      = 16'hB400;
    localparam logic [15:0] MISR_POLY      = 16'h1021;
    // An all-zero seed would lock the LFSR, so it is replaced by this value
    localparam logic [15:0] LFSR_ZERO_SEED = 16'h0001;

endpackage : scan_seq_pkg
`default_nettype wire

// File: rtl/scan_seq_ctrl_misr.sv
`default_nettype none
// ============================================================================
//  Module      : scan_misr
//  Description : Galois multiple-input signature register compacting the
//                scan chain outputs.
//  Revision    : 1.0 - initial release
// ============================================================================
module scan_misr
    import scan_seq_pkg::*;
#(
    parameter int               SIG_W = 16,
    parameter int               DIN_W = 2,
    parameter logic [SIG_W-1:0] POLY  = SIG_W'(MISR_POLY)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_en,
    input  logic             i_clr,
    input  logic [DIN_W-1:0] i_din,
    // Next-state value, so the parent can capture the signature on the same
    // edge as the final update
    output logic [SIG_W-1:0] o_misr_next
);

    logic [SIG_W-1:0] misr_q;
    logic [SIG_W-1:0] misr_d;

    // Clear has priority over a compaction step
    always_comb begin
        misr_d = misr_q;
        if (i_clr) begin
            misr_d = '0;
        end else if (i_en) begin
            misr_d = {misr_q[SIG_W-2:0], 1'b0}
                   ^ (misr_q[SIG_W-1] ? POLY : '0)
                   ^ SIG_W'(i_din);
        end
    end

    // Signature register
    always_ff @(posedge clk) begin
        if (rst) misr_q <= '0;
        else     misr_q <= misr_d;
    end

    assign o_misr_next = misr_d;

endmodule : scan_misr
`default_nettype wire

// File: rtl/scan_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : scan_seq_ctrl
//  Description : LBIST-lite scan sequencer: shifts LFSR patterns into two scan
//                chains, pulses capture, and compacts unloads into a MISR.
//  Revision    : 1.0 - initial release
// ============================================================================
module scan_seq_ctrl
    import scan_seq_pkg::*;
#(
    parameter int CHAIN_LEN  = 64,
    parameter int NUM_CHAINS = 2,
    parameter int PAT_W      = 16,
    parameter int SIG_W      = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  abort,
    input  logic [PAT_W-1:0]      pat_count,
    input  logic [SIG_W-1:0]      seed,
    input  logic [NUM_CHAINS-1:0] scan_do,
    output logic                  scan_se,
    output logic                  scan_clk_en,
    output logic [NUM_CHAINS-1:0] scan_di,
    output logic                  busy,
    output logic                  done,
    output logic [SIG_W-1:0]      signature
);

    localparam int             CNT_W      = $clog2(CHAIN_LEN);
    localparam logic [CNT_W-1:0] LAST_SHIFT = CNT_W'(CHAIN_LEN - 1);

    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        shift_cnt_q, shift_cnt_d;
    logic [PAT_W-1:0]        pat_cnt_q, pat_cnt_d;
    logic                    unload_q, unload_d;
    logic [SIG_W-1:0]        lfsr_q, lfsr_d, lfsr_step;
    logic                    scan_se_q, scan_se_d;
    logic                    scan_clk_en_q, scan_clk_en_d;
    logic [NUM_CHAINS-1:0]   scan_di_q, scan_di_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
    logic [SIG_W-1:0]        signature_q, signature_d;
    logic                    misr_en, misr_clr;
    logic [SIG_W-1:0]        misr_next;

    scan_misr #(
        .SIG_W (SIG_W),
        .DIN_W (NUM_CHAINS)
    ) u_misr (
        .clk         (clk),
        .rst         (rst),
        .i_en        (misr_en),
        .i_clr       (misr_clr),
        .i_din       (scan_do),
        .o_misr_next (misr_next)
    );

    // Next state, counters and LFSR; abort overrides every state
    always_comb begin
        lfsr_step   = {lfsr_q[SIG_W-2:0], ^(lfsr_q & SIG_W'(LFSR_TAPS))};
        state_d     = state_q;
        shift_cnt_d = shift_cnt_q;
        pat_cnt_d   = pat_cnt_q;
        unload_d    = unload_q;
        lfsr_d      = lfsr_q;
        misr_en     = 1'b0;
        misr_clr    = 1'b0;
        if (abort) begin
            state_d     = IDLE;
            shift_cnt_d = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        misr_clr    = 1'b1;
                        unload_d    = 1'b0;
                        pat_cnt_d   = pat_count;
                        shift_cnt_d = '0;
                        lfsr_d      = (seed == '0) ? SIG_W'(LFSR_ZERO_SEED) : seed;
                        state_d     = (pat_count == '0) ? DONE : SHIFT;
                    end
                end
                SHIFT: begin
                    lfsr_d  = lfsr_step;
                    misr_en = unload_q;
                    if (shift_cnt_q == LAST_SHIFT) begin
                        shift_cnt_d = '0;
                        state_d     = (pat_cnt_q != '0) ? SE_FALL : DONE;
                    end else begin
                        shift_cnt_d = shift_cnt_q + 1'b1;
                    end
                end
                SE_FALL: state_d = CAPTURE;
                CAPTURE: begin
                    pat_cnt_d = pat_cnt_q - 1'b1;
                    unload_d  = 1'b1;
                    state_d   = SE_RISE;
                end
                SE_RISE: state_d = SHIFT;
                DONE:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // Registered outputs are derived from the state being entered
    always_comb begin
        scan_se_d     = 1'b0;
        scan_clk_en_d = 1'b0;
        scan_di_d     = '0;
        busy_d        = (state_d != IDLE);
        done_d        = 1'b0;
        signature_d   = signature_q;
        case (state_d)
            SHIFT: begin
                scan_se_d     = 1'b1;
                scan_clk_en_d = 1'b1;
                // Unload-only window once every pattern has been captured
                if (pat_cnt_d != '0) scan_di_d = {lfsr_d[8], lfsr_d[0]};
            end
            SE_FALL: scan_di_d = scan_di_q;
            CAPTURE: begin
                scan_clk_en_d = 1'b1;
                scan_di_d     = scan_di_q;
            end
            SE_RISE: begin
                scan_se_d = 1'b1;
                scan_di_d = scan_di_q;
            end
            DONE: begin
                done_d      = 1'b1;
                signature_d = misr_next;
            end
            default: ;
        endcase
    end

    // State, datapath and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            shift_cnt_q   <= '0;
            pat_cnt_q     <= '0;
            unload_q      <= 1'b0;
            lfsr_q        <= SIG_W'(LFSR_ZERO_SEED);
            scan_se_q     <= 1'b0;
            scan_clk_en_q <= 1'b0;
            scan_di_q     <= '0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            signature_q   <= '0;
        end else begin
            state_q       <= state_d;
            shift_cnt_q   <= shift_cnt_d;
            pat_cnt_q     <= pat_cnt_d;
            unload_q      <= unload_d;
            lfsr_q        <= lfsr_d;
            scan_se_q     <= scan_se_d;
            scan_clk_en_q <= scan_clk_en_d;
            scan_di_q     <= scan_di_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            signature_q   <= signature_d;
        end
    end

    assign scan_se     = scan_se_q;
    assign scan_clk_en = scan_clk_en_q;
    assign scan_di     = scan_di_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign signature   = signature_q;

endmodule : scan_seq_ctrl
`default_nettype wire

// File: tb/tb_scan_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_scan_seq_ctrl
//  Description : Self-checking bench for scan_seq_ctrl with CHAIN_LEN=4.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_scan_seq_ctrl;

    localparam int CL = 4;

    logic        clk;
    logic        rst;
    logic        start;
    logic        abort;
    logic [15:0] pat_count;
    logic [15:0] seed;
    logic [1:0]  scan_do;
    logic        scan_se;
    logic        scan_clk_en;
    logic [1:0]  scan_di;
    logic        busy;
    logic        done;
    logic [15:0] signature;

    int          checks = 0;
    int          errors = 0;
    logic [15:0] exp_q[$];
    logic [15:0] mon_exp;
    logic [63:0] se_v, en_v, busy_v, done_v;
    logic [1:0]  di_first;

    scan_seq_ctrl #(
        .CHAIN_LEN  (CL),
        .NUM_CHAINS (2),
        .PAT_W      (16),
        .SIG_W      (16)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .abort       (abort),
        .pat_count   (pat_count),
        .seed        (seed),
        .scan_do     (scan_do),
        .scan_se     (scan_se),
        .scan_clk_en (scan_clk_en),
        .scan_di     (scan_di),
        .busy        (busy),
        .done        (done),
        .signature   (signature)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic void check(input string name, input logic [63:0] act,
                                  input logic [63:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp_v);
        end
    endfunction

    // Reference Fibonacci LFSR step
    function automatic logic [15:0] lfsr_nx(input logic [15:0] l);
        return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
    endfunction

    // Scoreboard monitor: every done pulse must match the oldest expected signature
    always @(negedge clk) begin
        if (done) begin
            if (exp_q.size() == 0) begin
                check("unexpected_done", 64'd1, 64'd0);
            end else begin
                mon_exp = exp_q.pop_front();
                check("signature_at_done", 64'(signature), 64'(mon_exp));
            end
        end
    end

    task automatic drive_start(input logic [15:0] s, input logic [15:0] p,
                               input logic [1:0] d);
        @(posedge clk); #1;
        start = 1'b1; pat_count = p; seed = s; scan_do = d;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Full run: records per-cycle waveforms, checks scan_di against the LFSR
    // model, and checks the busy length
    task automatic run(input logic [15:0] s, input logic [15:0] p,
                       input logic [1:0] d, input logic [15:0] exp_sig);
        logic [15:0] l;
        logic [1:0]  exp_di;
        int          shifts;
        int          busy_n;
        int          exp_busy;
        bit          fin;
        l = (s == 16'h0) ? 16'h0001 : s;
        se_v = '0; en_v = '0; busy_v = '0; done_v = '0; di_first = 2'bxx;
        shifts = 0; busy_n = 0; fin = 1'b0;
        exp_q.push_back(exp_sig);
        drive_start(s, p, d);
        for (int c = 1; c < 300 && !fin; c++) begin
            @(negedge clk);
            if (c < 64) begin
                se_v[c] = scan_se; en_v[c] = scan_clk_en;
                busy_v[c] = busy;  done_v[c] = done;
            end
            if (busy) busy_n++;
            else      fin = 1'b1;
            if (scan_se && scan_clk_en) begin
                exp_di = (shifts / CL == int'(p)) ? 2'b00 : {l[8], l[0]};
                if (shifts == 0) di_first = scan_di;
                check("scan_di", 64'(scan_di), 64'(exp_di));
                l = lfsr_nx(l);
                shifts++;
            end
        end
        check("run_terminated", 64'(fin), 64'd1);
        exp_busy = (p == 16'h0) ? 1 : (int'(p) + 1) * CL + 3 * int'(p) + 1;
        check("busy_cycles", 64'(busy_n), 64'(exp_busy));
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; abort = 1'b0;
        pat_count = '0; seed = '0; scan_do = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_done", 64'(done), 64'd0);
        check("reset_se", 64'(scan_se), 64'd0);
        check("reset_clk_en", 64'(scan_clk_en), 64'd0);
        check("reset_di", 64'(scan_di), 64'd0);
        check("reset_signature", 64'(signature), 64'd0);

        // pat_count=1, seed 0, scan_do=01: four unload updates -> 16'h000F
        run(16'h0000, 16'd1, 2'b01, 16'h000F);
        check("t1_se_wave", se_v, 64'h0F9E);
        check("t1_clk_en_wave", en_v, 64'h0F5E);
        check("t1_busy_wave", busy_v, 64'h1FFE);
        check("t1_done_wave", done_v, 64'h1000);
        check("t1_first_di_seed0", 64'(di_first), 64'h1);
        repeat (3) @(negedge clk);
        check("t1_signature_hold", 64'(signature), 64'h000F);

        // pat_count=0: done one cycle after start, signature cleared
        run(16'h1234, 16'd0, 2'b11, 16'h0000);
        check("t0_busy_wave", busy_v, 64'h2);
        check("t0_done_wave", done_v, 64'h2);
        check("t0_se_wave", se_v, 64'h0);
        check("t0_signature", 64'(signature), 64'h0);

        // Seeded run, two patterns, scan_do=11: eight updates -> 16'h0101
        run(16'hACE1, 16'd2, 2'b11, 16'h0101);
        check("t2_first_di", 64'(di_first), 64'h1);

        // Abort while in CAPTURE (cycle 6)
        drive_start(16'h0000, 16'd1, 2'b01);
        repeat (5) @(posedge clk);
        @(negedge clk);
        check("ab_capture_se", 64'(scan_se), 64'd0);
        check("ab_capture_clk_en", 64'(scan_clk_en), 64'd1);
        @(posedge clk); #1 abort = 1'b1;
        @(posedge clk); #1 abort = 1'b0;
        @(negedge clk);
        check("ab_busy", 64'(busy), 64'd0);
        check("ab_se", 64'(scan_se), 64'd0);
        check("ab_clk_en", 64'(scan_clk_en), 64'd0);
        check("ab_di", 64'(scan_di), 64'd0);
        check("ab_done", 64'(done), 64'd0);
        check("ab_signature", 64'(signature), 64'h0101);
        repeat (12) @(negedge clk);
        check("ab_still_idle", 64'(busy), 64'd0);
        run(16'h0000, 16'd1, 2'b01, 16'h000F);

        // Abort and start together in IDLE: abort wins
        @(posedge clk); #1;
        start = 1'b1; abort = 1'b1; pat_count = 16'd1;
        @(posedge clk); #1;
        start = 1'b0; abort = 1'b0;
        @(negedge clk);
        check("abst_busy", 64'(busy), 64'd0);
        check("abst_signature", 64'(signature), 64'h000F);

        // Re-pulsed start while busy is ignored; reset at cycle 3
        drive_start(16'h1234, 16'd1, 2'b01);
        @(posedge clk); #1;
        start = 1'b1; pat_count = 16'd0;
        @(posedge clk); #1;
        start = 1'b0; rst = 1'b1;
        @(negedge clk);
        check("rp_busy", 64'(busy), 64'd1);
        check("rp_se", 64'(scan_se), 64'd1);
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_se", 64'(scan_se), 64'd0);
        check("rst_clk_en", 64'(scan_clk_en), 64'd0);
        check("rst_di", 64'(scan_di), 64'd0);
        check("rst_signature", 64'(signature), 64'd0);
        run(16'h0000, 16'd1, 2'b01, 16'h000F);

        // Five patterns: twenty updates, polynomial feedback engaged -> 16'h0E10
        run(16'hBEEF, 16'd5, 2'b01, 16'h0E10);

        repeat (4) @(negedge clk);
        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_scan_seq_ctrl
`default_nettype wire
